// File: rtl/reg_bus_arbiter.sv
// Round-robin arbiter/sequencer sharing one register-file port between NUM_REQ masters.
// One transaction at a time: IDLE -> ISSUE -> [WAIT x RD_LATENCY] -> RESP -> IDLE.
module reg_bus_arbiter #(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ-1:0]         req_write,
    input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]         req_ack,
    output logic [DATA_W-1:0]          req_rdata,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic [ADDR_W-1:0]          int_address,
    output logic [DATA_W-1:0]          int_wr_data,
    output logic                       int_write,
    output logic                       int_read,
    input  logic [DATA_W-1:0]          int_rd_data
);

    localparam int unsigned IdW  = $clog2(NUM_REQ);
    localparam int unsigned CntW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e              state_q, state_d;
    logic [IdW-1:0]      last_q, last_d;
    logic [IdW-1:0]      grant_q, grant_d;
    logic                is_write_q, is_write_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                int_write_q, int_write_d;
    logic                int_read_q, int_read_d;
    logic [NUM_REQ-1:0]  ack_q, ack_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic                busy_q, busy_d;

    logic                any_req;
    logic [IdW-1:0]      winner;
    logic [IdW-1:0]      cand;

    // Scan last+1, last+2, ... so the most recently served master has lowest priority.
    always_comb begin
        any_req = 1'b0;
        winner  = last_q;
        cand    = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = IdW'((32'(last_q) + k) % NUM_REQ);
            if (!any_req && req_valid[cand]) begin
                any_req = 1'b1;
                winner  = cand;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        grant_d     = grant_q;
        is_write_d  = is_write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        cnt_d       = cnt_q;
        int_write_d = 1'b0;
        int_read_d  = 1'b0;
        ack_d       = '0;

        unique case (state_q)
            StIdle: begin
                if (any_req) begin
                    state_d     = StIssue;
                    last_d      = winner;
                    grant_d     = winner;
                    is_write_d  = req_write[winner];
                    addr_d      = req_addr[winner*ADDR_W +: ADDR_W];
                    wdata_d     = req_wdata[winner*DATA_W +: DATA_W];
                    // Strobes are registered, so they are raised on entry to ISSUE.
                    int_write_d = req_write[winner];
                    int_read_d  = !req_write[winner];
                end
            end
            StIssue: begin
                if (is_write_q) begin
                    state_d        = StResp;
                    ack_d[grant_q] = 1'b1;
                end else begin
                    state_d = StWait;
                    cnt_d   = CntW'(RD_LATENCY - 1);
                end
            end
            StWait: begin
                if (cnt_q == '0) begin
                    state_d        = StResp;
                    rdata_d        = int_rd_data;
                    ack_d[grant_q] = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StIdle;
            last_q      <= IdW'(NUM_REQ - 1);
            grant_q     <= '0;
            is_write_q  <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            int_write_q <= 1'b0;
            int_read_q  <= 1'b0;
            ack_q       <= '0;
            rdata_q     <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            grant_q     <= grant_d;
            is_write_q  <= is_write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            int_write_q <= int_write_d;
            int_read_q  <= int_read_d;
            ack_q       <= ack_d;
            rdata_q     <= rdata_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
        end
    end

    assign req_ack     = ack_q;
    assign req_rdata   = rdata_q;
    assign grant_id    = grant_q;
    assign busy        = busy_q;
    assign int_address = addr_q;
    assign int_wr_data = wdata_q;
    assign int_write   = int_write_q;
    assign int_read    = int_read_q;

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Bench for reg_bus_arbiter: two builds (RD_LATENCY 1 and 3), a register-file model per build,
// and a transaction-timeline reference model checked against every output every cycle.
module tb_reg_bus_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst   [2];
    logic [1:0] rv    [2];
    logic [1:0] rw    [2];
    logic [15:0] ra   [2];
    logic [15:0] rwd  [2];
    logic [1:0] ack   [2];
    logic [7:0] rdata [2];
    logic [0:0] gid   [2];
    logic       busy  [2];
    logic [7:0] iaddr [2];
    logic [7:0] iwd   [2];
    logic       iw    [2];
    logic       ir    [2];
    logic [7:0] ird   [2];

    reg_bus_arbiter #(.NUM_REQ(2), .ADDR_W(8), .DATA_W(8), .RD_LATENCY(1)) u_dut0 (
        .clock(clk), .reset(rst[0]), .req_valid(rv[0]), .req_write(rw[0]),
        .req_addr(ra[0]), .req_wdata(rwd[0]), .req_ack(ack[0]), .req_rdata(rdata[0]),
        .grant_id(gid[0]), .busy(busy[0]), .int_address(iaddr[0]), .int_wr_data(iwd[0]),
        .int_write(iw[0]), .int_read(ir[0]), .int_rd_data(ird[0])
    );

    reg_bus_arbiter #(.NUM_REQ(2), .ADDR_W(8), .DATA_W(8), .RD_LATENCY(3)) u_dut1 (
        .clock(clk), .reset(rst[1]), .req_valid(rv[1]), .req_write(rw[1]),
        .req_addr(ra[1]), .req_wdata(rwd[1]), .req_ack(ack[1]), .req_rdata(rdata[1]),
        .grant_id(gid[1]), .busy(busy[1]), .int_address(iaddr[1]), .int_wr_data(iwd[1]),
        .int_write(iw[1]), .int_read(ir[1]), .int_rd_data(ird[1])
    );

    // Register file: read data is valid exactly RD_LATENCY cycles after the strobe, junk otherwise.
    int         seed;
    logic       rf_init;
    logic [7:0] rf_mem [2][256];
    logic       pv     [2][3];
    logic [7:0] pd     [2][3];

    function automatic logic [7:0] init_byte(input int a);
        return 8'(a * 29) ^ seed[7:0];
    endfunction

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rf_init) begin
                for (int a = 0; a < 256; a++) rf_mem[d][a] <= init_byte(a);
                for (int s = 0; s < 3; s++) pv[d][s] <= 1'b0;
            end else begin
                if (iw[d]) rf_mem[d][iaddr[d]] <= iwd[d];
                pv[d][0] <= ir[d];
                for (int s = 1; s < 3; s++) pv[d][s] <= pv[d][s-1];
            end
            pd[d][0] <= rf_mem[d][iaddr[d]];
            for (int s = 1; s < 3; s++) pd[d][s] <= pd[d][s-1];
        end
    end

    always_comb begin
        ird[0] = pv[0][0] ? pd[0][0] : 8'hEE;
        ird[1] = pv[1][2] ? pd[1][2] : 8'hEE;
    end

    // Reference model: each transaction is a timeline anchored at its sampling edge t0.
    int         checks, errors, cyc;
    logic [7:0] exp_mem [2][256];
    int         idle_from [2];
    int         t0 [2];
    int         ack_c [2];
    int         last [2];
    int         tid [2];
    bit         infl [2];
    bit         tw [2];
    logic [7:0] trd [2];
    logic [1:0] e_ack [2];
    logic [7:0] e_rdata [2];
    logic [7:0] e_addr [2];
    logic [7:0] e_wd [2];
    int         e_gid [2];
    bit         e_busy [2];
    bit         e_iw [2];
    bit         e_ir [2];
    int         id, n;

    function automatic int lat(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset(input int d);
        infl[d] = 1'b0; last[d] = 1; idle_from[d] = cyc;
        e_ack[d] = '0; e_rdata[d] = '0; e_addr[d] = '0; e_wd[d] = '0;
        e_gid[d] = 0; e_busy[d] = 1'b0; e_iw[d] = 1'b0; e_ir[d] = 1'b0;
    endtask

    task automatic model_edge(input int d);
        if (rst[d]) begin
            model_reset(d);
        end else begin
            if (infl[d] && cyc > ack_c[d]) infl[d] = 1'b0;
            if (!infl[d] && cyc - 1 >= idle_from[d] && rv[d] != 2'b00) begin
                int w = -1;
                for (int k = 1; k <= 2; k++) begin
                    if (w < 0 && rv[d][(last[d] + k) % 2]) w = (last[d] + k) % 2;
                end
                last[d] = w; tid[d] = w; e_gid[d] = w;
                tw[d] = rw[d][w];
                e_addr[d] = ra[d][w*8 +: 8];
                e_wd[d] = rwd[d][w*8 +: 8];
                t0[d] = cyc;
                ack_c[d] = cyc + 1 + (tw[d] ? 0 : lat(d));
                idle_from[d] = ack_c[d] + 1;
                infl[d] = 1'b1;
                if (tw[d]) exp_mem[d][e_addr[d]] = e_wd[d];
                else trd[d] = exp_mem[d][e_addr[d]];
            end
            e_iw[d] = infl[d] && tw[d] && cyc == t0[d];
            e_ir[d] = infl[d] && !tw[d] && cyc == t0[d];
            e_ack[d] = (infl[d] && cyc == ack_c[d]) ? 2'(1 << tid[d]) : 2'b00;
            if (infl[d] && !tw[d] && cyc == ack_c[d]) e_rdata[d] = trd[d];
            e_busy[d] = infl[d];
        end
    endtask

    task automatic check_outputs(input int d);
        chk($sformatf("d%0d req_ack", d), 32'(ack[d]), 32'(e_ack[d]));
        chk($sformatf("d%0d req_rdata", d), 32'(rdata[d]), 32'(e_rdata[d]));
        chk($sformatf("d%0d grant_id", d), 32'(gid[d]), 32'(e_gid[d]));
        chk($sformatf("d%0d busy", d), 32'(busy[d]), 32'(e_busy[d]));
        chk($sformatf("d%0d int_address", d), 32'(iaddr[d]), 32'(e_addr[d]));
        chk($sformatf("d%0d int_wr_data", d), 32'(iwd[d]), 32'(e_wd[d]));
        chk($sformatf("d%0d int_write", d), 32'(iw[d]), 32'(e_iw[d]));
        chk($sformatf("d%0d int_read", d), 32'(ir[d]), 32'(e_ir[d]));
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        model_edge(0);
        model_edge(1);
        @(negedge clk);
        check_outputs(0);
        check_outputs(1);
    endtask

    task automatic set_req(input int d, input int i, input bit v, input bit w,
                           input logic [7:0] a, input logic [7:0] wd);
        rv[d][i] = v;
        rw[d][i] = w;
        ra[d][i*8 +: 8] = a;
        rwd[d][i*8 +: 8] = wd;
    endtask

    task automatic rand_req(input int i);
        set_req(0, i, 1'b1, 1'($urandom_range(1)), 8'($urandom_range(15)), 8'($urandom));
    endtask

    // Steps until an ack appears on build d; n = cycles from the sampling IDLE cycle.
    task automatic wait_any_ack(input int d, output int got, output int cnt);
        got = -1;
        cnt = 0;
        while (got < 0 && cnt < 20) begin
            step();
            cnt++;
            if (ack[d] == 2'b01) got = 0;
            else if (ack[d] == 2'b10) got = 1;
        end
        chk($sformatf("d%0d ack_seen", d), 32'(got >= 0), 32'd1);
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0;
        seed = int'($urandom);
        rf_init = 1'b1;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; rv[d] = '0; rw[d] = '0; ra[d] = '0; rwd[d] = '0;
            model_reset(d);
            for (int a = 0; a < 256; a++) exp_mem[d][a] = init_byte(a);
        end
        step();
        rf_init = 1'b0;
        step();
        rst[0] = 1'b0;
        rst[1] = 1'b0;

        // 1: master 0 write, ack two cycles after sampling
        set_req(0, 0, 1'b1, 1'b1, 8'h10, 8'hA5);
        wait_any_ack(0, id, n);
        chk("t1 ack_id", 32'(id), 32'd0);
        chk("t1 latency", 32'(n), 32'd2);
        set_req(0, 0, 1'b0, 1'b0, 8'h00, 8'h00);
        step();

        // 2: master 1 reads back
        set_req(0, 1, 1'b1, 1'b0, 8'h10, 8'h00);
        wait_any_ack(0, id, n);
        chk("t2 ack_id", 32'(id), 32'd1);
        chk("t2 latency", 32'(n), 32'd3);
        chk("t2 rdata", 32'(rdata[0]), 32'hA5);
        set_req(0, 1, 1'b0, 1'b0, 8'h00, 8'h00);
        step();

        // 3: both masters request continuously; grants alternate starting at 0
        rand_req(0);
        rand_req(1);
        for (int t = 0; t < 6; t++) begin
            wait_any_ack(0, id, n);
            chk($sformatf("t3 grant%0d", t), 32'(id), 32'(t % 2));
            if (id >= 0) rand_req(id);
        end
        if (id >= 0) set_req(0, id, 1'b0, 1'b0, 8'h00, 8'h00);
        wait_any_ack(0, id, n);
        chk("t3 tail_id", 32'(id), 32'd0);
        set_req(0, 0, 1'b0, 1'b0, 8'h00, 8'h00);
        step();

        // 4: master 0 read; its fields change after grant; master 1 arrives during WAIT
        set_req(0, 0, 1'b1, 1'b0, 8'h10, 8'h00);
        step();
        set_req(0, 0, 1'b1, 1'b1, 8'h20, 8'h77);
        step();
        set_req(0, 1, 1'b1, 1'b0, 8'h30, 8'h00);
        wait_any_ack(0, id, n);
        chk("t4 first_id", 32'(id), 32'd0);
        chk("t4 rdata_orig", 32'(rdata[0]), 32'hA5);
        wait_any_ack(0, id, n);
        chk("t4 next_id", 32'(id), 32'd1);
        set_req(0, 1, 1'b0, 1'b0, 8'h00, 8'h00);
        wait_any_ack(0, id, n);
        chk("t4 last_id", 32'(id), 32'd0);
        set_req(0, 0, 1'b0, 1'b0, 8'h00, 8'h00);
        step();

        // 5: reset during WAIT of a read aborts it; a fresh write then completes
        set_req(0, 0, 1'b1, 1'b0, 8'h10, 8'h00);
        step();
        step();
        rst[0] = 1'b1;
        set_req(0, 0, 1'b0, 1'b0, 8'h00, 8'h00);
        step();
        chk("t5 ack_after_rst", 32'(ack[0]), 32'd0);
        chk("t5 busy_after_rst", 32'(busy[0]), 32'd0);
        rst[0] = 1'b0;
        set_req(0, 0, 1'b1, 1'b1, 8'h30, 8'h5A);
        wait_any_ack(0, id, n);
        chk("t5 write_id", 32'(id), 32'd0);
        chk("t5 write_latency", 32'(n), 32'd2);
        set_req(0, 0, 1'b0, 1'b0, 8'h00, 8'h00);
        step();
        set_req(0, 1, 1'b1, 1'b0, 8'h30, 8'h00);
        wait_any_ack(0, id, n);
        chk("t5 readback", 32'(rdata[0]), 32'h5A);
        set_req(0, 1, 1'b0, 1'b0, 8'h00, 8'h00);
        step();

        // 6: RD_LATENCY=3 build
        set_req(1, 0, 1'b1, 1'b1, 8'hFF, 8'h3C);
        wait_any_ack(1, id, n);
        chk("t6 write_latency", 32'(n), 32'd2);
        set_req(1, 0, 1'b0, 1'b0, 8'h00, 8'h00);
        step();
        set_req(1, 0, 1'b1, 1'b0, 8'hFF, 8'h00);
        wait_any_ack(1, id, n);
        chk("t6 read_latency", 32'(n), 32'd5);
        chk("t6 rdata", 32'(rdata[1]), 32'h3C);
        set_req(1, 0, 1'b0, 1'b0, 8'h00, 8'h00);
        step();

        // Random traffic on the latency-1 build, with one reset pulse part way through
        for (int k = 0; k < 400; k++) begin
            if (k == 200) begin
                rst[0] = 1'b1;
                rv[0] = 2'b00;
                step();
                rst[0] = 1'b0;
            end
            step();
            for (int i = 0; i < 2; i++) begin
                if (ack[0][i]) begin
                    if ($urandom_range(3) != 0) rand_req(i);
                    else set_req(0, i, 1'b0, 1'b0, 8'h00, 8'h00);
                end else if (!rv[0][i] && $urandom_range(1) == 1) begin
                    rand_req(i);
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
